// File: rtl/retospect_bs_loader_if.sv
// Byte stream into the configuration-chain loader and the readback byte strobe out of it.
interface retospect_bs_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/retospect_bs_loader.sv
// Serialises configuration bytes onto the neurochip shift chain, one bit per clock, and
// returns the displaced tail bits as readback bytes. An optional neuron reset pulse follows.
module retospect_bs_loader #(
    parameter int CHAIN_LEN = 523,
    parameter bit NN_PULSE  = 1'b1,
    parameter int CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    retospect_bs_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 config_en,
    output logic                 bs_in,
    input  logic                 bs_out,
    output logic                 reset_nn
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SHIFT,
        NNRST,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_byte;
    logic [7:0]       rd_shadow;
    logic [7:0]       rd_next;
    logic             chain_end;
    logic             final_bit;
    logic             take;

    // Readback byte including the tail bit sampled on the current shift edge.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        rd_next          = rd_shadow;
        rd_next[bit_idx] = bs_out;
    end

    assign chain_end = (bit_cnt == LAST_BIT);
    assign final_bit = (bit_idx == 3'd7) || chain_end;
    assign take      = bus.in_valid & bus.in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shift_byte   <= '0;
            rd_shadow    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            config_en    <= 1'b0;
            bs_in        <= 1'b0;
            reset_nn     <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            done         <= 1'b0;
            reset_nn     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= WAIT;
                        busy         <= 1'b1;
                        bit_cnt      <= '0;
                        rd_shadow    <= '0;
                        bus.in_ready <= 1'b1;
                    end
                end

                WAIT: begin
                    if (take) begin
                        shift_byte   <= bus.in_data;
                        bit_idx      <= '0;
                        bs_in        <= bus.in_data[0];
                        config_en    <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= SHIFT;
                    end
                end

                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (!final_bit) begin
                        rd_shadow    <= rd_next;
                        bit_idx      <= bit_idx + 3'd1;
                        bs_in        <= shift_byte[bit_idx + 3'd1];
                        // Open the handshake one cycle early so the next byte lands on the final-bit edge.
                        bus.in_ready <= (bit_idx == 3'd6) && ((bit_cnt + CNT_W'(1)) != LAST_BIT);
                    end else begin
                        bus.rd_data  <= rd_next;
                        bus.rd_valid <= 1'b1;
                        rd_shadow    <= '0;
                        if (chain_end) begin
                            config_en    <= 1'b0;
                            bus.in_ready <= 1'b0;
                            if (NN_PULSE) begin
                                state    <= NNRST;
                                reset_nn <= 1'b1;
                            end else begin
                                state <= FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else if (take) begin
                            shift_byte   <= bus.in_data;
                            bit_idx      <= '0;
                            bs_in        <= bus.in_data[0];
                            bus.in_ready <= 1'b0;
                        end else begin
                            config_en    <= 1'b0;
                            bus.in_ready <= 1'b1;
                            state        <= WAIT;
                        end
                    end
                end

                NNRST: begin
                    state <= FIN;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench: a 523-bit chain model in loopback, a readback scoreboard fed by a bit-order
// image model, and a second instance built without the neuron reset pulse.
module tb_retospect_bs_loader;
    localparam int CHAIN_LEN = 523;
    localparam int NBYTES    = (CHAIN_LEN + 7) / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, config_en, bs_in, bs_out, reset_nn;

    logic start0 = 1'b0;
    logic busy0, done0, en0, bsin0, nn0;

    retospect_bs_loader_if bus ();
    retospect_bs_loader_if bus0 ();

    retospect_bs_loader #(.CHAIN_LEN(CHAIN_LEN), .NN_PULSE(1'b1), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave), .busy(busy), .done(done),
        .config_en(config_en), .bs_in(bs_in), .bs_out(bs_out), .reset_nn(reset_nn)
    );

    retospect_bs_loader #(.CHAIN_LEN(CHAIN_LEN), .NN_PULSE(1'b0), .CNT_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0.slave), .busy(busy0), .done(done0),
        .config_en(en0), .bs_in(bsin0), .bs_out(1'b0), .reset_nn(nn0)
    );

    always #5 clk = ~clk;

    // Chain model: not reset by rst_n, so an aborted load leaves a partial image behind.
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge clk) if (config_en) chain <= {chain[CHAIN_LEN-2:0], bs_in};
    assign bs_out = chain[CHAIN_LEN-1];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] load_buf [NBYTES];
    logic [7:0] exp_q [$];
    bit         img_q [$];

    int shift_no, run, max_run, acc_cnt, nn_cnt, nn_cyc, done_cnt, done_cyc, last_en_cyc, rd_cnt;
    int en0_cnt, en0_last, nn0_cnt, done0_cnt, done0_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected readback: image bits leave tail-first while the new bits enter behind them.
    function automatic void plan_shift(input int nbits);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < nbits; i++) begin
            acc[i % 8] = img_q.pop_front();
            img_q.push_back(load_buf[i / 8][i % 8]);
            if ((i % 8 == 7) || (i == CHAIN_LEN - 1)) begin
                exp_q.push_back(acc);
                acc = '0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_cnt++;
        if (config_en) begin
            if (shift_no < CHAIN_LEN) check("bs_in", bs_in, load_buf[shift_no / 8][shift_no % 8]);
            shift_no++;
            run++;
            if (run > max_run) max_run = run;
            last_en_cyc = cyc;
        end else begin
            run = 0;
        end
        if (reset_nn) begin
            check("nn_with_en", config_en, 1'b0);
            nn_cnt++;
            nn_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.rd_valid) begin
            rd_cnt++;
            if (exp_q.size() == 0) check("rd_extra", rd_cnt, 0);
            else check($sformatf("rd_byte%0d", rd_cnt - 1), bus.rd_data, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (en0) begin
            en0_cnt++;
            en0_last = cyc;
        end
        if (nn0) nn0_cnt++;
        if (done0) begin
            done0_cnt++;
            done0_cyc = cyc;
        end
    end

    task automatic run_load(input string name, input bit gaps, input int abort_at, input bit start_mid);
        bit finished;
        int k;
        finished = 1'b0;
        k = 0;
        shift_no = 0; run = 0; max_run = 0; acc_cnt = 0; nn_cnt = 0; done_cnt = 0; rd_cnt = 0;
        nn_cyc = -1; done_cyc = -1; last_en_cyc = -1;
        // A synchronous reset lands on an edge where the chain still shifts, hence one extra bit.
        plan_shift((abort_at > 0) ? abort_at + 1 : CHAIN_LEN);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy_start"}, busy, 1'b1);
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (abort_at > 0 && shift_no >= abort_at) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check({name, "_abort_en"}, config_en, 1'b0);
                check({name, "_abort_busy"}, busy, 1'b0);
                repeat (20) @(posedge clk);
                #1;
                check({name, "_abort_rd_count"}, rd_cnt, (abort_at + 1) / 8);
                check({name, "_abort_shifts"}, shift_no, abort_at + 1);
                check({name, "_abort_done"}, done_cnt, 0);
                return;
            end
            start = start_mid && (c == 100);
            bus.in_data = (k < NBYTES) ? load_buf[k] : 8'hEE;
            bus.in_valid = gaps ? (c % 3 == 0) : 1'b1;
            if (bus.in_valid && bus.in_ready && k < NBYTES) k++;
            @(posedge clk); #1;
            finished = (done_cnt > 0);
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        check({name, "_done_seen"}, finished, 1'b1);
        check({name, "_accepts"}, acc_cnt, NBYTES);
        check({name, "_en_cycles"}, shift_no, CHAIN_LEN);
        if (gaps) check({name, "_en_gapped"}, max_run < CHAIN_LEN, 1'b1);
        else check({name, "_en_run"}, max_run, CHAIN_LEN);
        check({name, "_nn_count"}, nn_cnt, 1);
        check({name, "_nn_at"}, nn_cyc, last_en_cyc + 1);
        check({name, "_done_at"}, done_cyc, nn_cyc + 1);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_rd_count"}, rd_cnt, NBYTES);
        check({name, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus0.in_data = '0;
        bus0.in_valid = 1'b0;
        en0_cnt = 0; nn0_cnt = 0; done0_cnt = 0; en0_last = -1; done0_cyc = -1;
        shift_no = 0; run = 0; max_run = 0; acc_cnt = 0; nn_cnt = 0; done_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < CHAIN_LEN; i++) img_q.push_back(1'b0);
        for (int i = 0; i < NBYTES; i++) load_buf[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_config_en", config_en, 1'b0);
        check("rst_bs_in", bs_in, 1'b0);
        check("rst_reset_nn", reset_nn, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'hA5;
        run_load("a5_stream", 1'b0, 0, 1'b0);

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'(i);
        run_load("ramp", 1'b0, 0, 1'b0);

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'hFF;
        run_load("ones", 1'b0, 0, 1'b0);

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'hA5;
        run_load("a5_gapped", 1'b1, 0, 1'b1);

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'(i * 3 + 1);
        run_load("abort", 1'b0, 200, 1'b0);

        for (int i = 0; i < NBYTES; i++) load_buf[i] = 8'h5A;
        run_load("after_abort", 1'b0, 0, 1'b0);

        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        bus0.in_data = 8'h3C;
        bus0.in_valid = 1'b1;
        for (int c = 0; c < 2000 && done0_cnt == 0; c++) begin
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        check("nopulse_done_count", done0_cnt, 1);
        check("nopulse_en_cycles", en0_cnt, CHAIN_LEN);
        check("nopulse_nn_count", nn0_cnt, 0);
        check("nopulse_done_at", done0_cyc, en0_last + 1);
        check("nopulse_busy_end", busy0, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
